// File: rtl/xem5010_mem_arbiter.sv
// xem5010_mem_arbiter
// Demand-driven scheduler between a 64-bit write requester and a read requester
// in front of the XEM5010 DDR2 MIG application interface. It serialises each
// granted request into MIG command/write-data beats, assembles two returned read
// beats into one 64-bit response and bounds the reads in flight.
//
// Ports
//   s_clk, s_rst            clock, synchronous active-high reset
//   s_phy_init_done         MIG calibration complete; no grants while low
//   wr_req_valid/addr/data  write request (held stable until wr_req_ready)
//   wr_req_ready            write accepted this cycle (combinational)
//   rd_req_valid/addr       read request (held stable until rd_req_ready)
//   rd_req_ready            read accepted this cycle (combinational)
//   rd_resp_valid/data      one-cycle response pulse, {second beat, first beat}
//   rd_outstanding          read commands issued but not yet fully returned
//   s_app_af_afull          MIG command FIFO almost full
//   s_app_wdf_afull         MIG write-data FIFO almost full
//   s_app_rd_data_valid/data  MIG read beat
//   s_app_af_wren/cmd/addr  MIG command FIFO write (cmd 000 write, 001 read)
//   s_app_wdf_wren/data     MIG write-data FIFO write
//   s_app_wdf_mask_data     write mask, tied to zero
module xem5010_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 31,
  parameter int unsigned MAX_RUN         = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  s_phy_init_done,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [63:0]           wr_req_data,
  output logic                  wr_req_ready,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_ready,
  output logic                  rd_resp_valid,
  output logic [63:0]           rd_resp_data,
  output logic [3:0]            rd_outstanding,
  input  logic                  s_app_af_afull,
  input  logic                  s_app_wdf_afull,
  input  logic                  s_app_rd_data_valid,
  input  logic [31:0]           s_app_rd_data,
  output logic                  s_app_af_wren,
  output logic [2:0]            s_app_af_cmd,
  output logic [ADDR_WIDTH-1:0] s_app_af_addr,
  output logic                  s_app_wdf_wren,
  output logic [31:0]           s_app_wdf_data,
  output logic [3:0]            s_app_wdf_mask_data
);

  localparam int unsigned RUN_W = 8;
  localparam int unsigned OUT_W = 4;

  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_SAT   = '1;
  localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [2:0]       CMD_WR    = 3'b000;
  localparam logic [2:0]       CMD_RD    = 3'b001;

  typedef enum logic {IDLE, WR_HI} state_t;
  typedef enum logic {TYPE_WR, TYPE_RD} req_type_t;

  state_t           state;
  req_type_t        last_type;
  logic [RUN_W-1:0] run_count;
  logic [31:0]      wr_hi_data;
  logic             beat_toggle;
  logic [31:0]      rd_low;

  logic      wr_elig;
  logic      rd_elig;
  logic      keep_last;
  logic      grant_wr;
  logic      grant_rd;
  req_type_t grant_type;
  logic      rd_beat;
  logic      rd_done;

  assign s_app_wdf_mask_data = 4'b0000;

  // Eligibility, fairness-limited arbitration and read-return qualification
  always_comb begin
    wr_elig    = 1'b0;
    rd_elig    = 1'b0;
    keep_last  = 1'b0;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    grant_type = TYPE_WR;
    rd_beat    = 1'b0;
    rd_done    = 1'b0;

    if (!s_rst && state == IDLE && s_phy_init_done && !s_app_af_afull) begin
      wr_elig = wr_req_valid && !s_app_wdf_afull;
      rd_elig = rd_req_valid && (rd_outstanding < OUT_LIMIT);
    end

    // With both eligible: stay on last_type until its run is used up, then switch.
    keep_last = (run_count < RUN_LIMIT);
    grant_wr  = wr_elig && (!rd_elig || ((last_type == TYPE_WR) == keep_last));
    grant_rd  = rd_elig && !grant_wr;
    grant_type = grant_rd ? TYPE_RD : TYPE_WR;

    // Beats arriving with nothing outstanding are stray and ignored.
    rd_beat = s_app_rd_data_valid && (rd_outstanding != '0);
    rd_done = rd_beat && beat_toggle;
  end

  assign wr_req_ready = grant_wr;
  assign rd_req_ready = grant_rd;

  // FSM, MIG output registers, run tracking and read-return assembly
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state          <= IDLE;
      last_type      <= TYPE_WR;
      run_count      <= '0;
      wr_hi_data     <= '0;
      beat_toggle    <= 1'b0;
      rd_low         <= '0;
      rd_outstanding <= '0;
      rd_resp_valid  <= 1'b0;
      rd_resp_data   <= '0;
      s_app_af_wren  <= 1'b0;
      s_app_af_cmd   <= CMD_WR;
      s_app_af_addr  <= '0;
      s_app_wdf_wren <= 1'b0;
      s_app_wdf_data <= '0;
    end else begin
      s_app_af_wren  <= 1'b0;
      s_app_wdf_wren <= 1'b0;
      rd_resp_valid  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_wr) begin
            s_app_af_wren  <= 1'b1;
            s_app_af_cmd   <= CMD_WR;
            s_app_af_addr  <= wr_req_addr;
            s_app_wdf_wren <= 1'b1;
            s_app_wdf_data <= wr_req_data[31:0];
            wr_hi_data     <= wr_req_data[63:32];
            state          <= WR_HI;
          end else if (grant_rd) begin
            s_app_af_wren  <= 1'b1;
            s_app_af_cmd   <= CMD_RD;
            s_app_af_addr  <= rd_req_addr;
          end
        end
        WR_HI: begin
          // Second write beat is issued unconditionally; flags were checked at grant.
          s_app_wdf_wren <= 1'b1;
          s_app_wdf_data <= wr_hi_data;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (grant_wr || grant_rd) begin
        if (grant_type == last_type) begin
          if (run_count != RUN_SAT) begin
            run_count <= run_count + RUN_W'(1);
          end
        end else begin
          run_count <= RUN_W'(1);
          last_type <= grant_type;
        end
      end

      if (rd_beat) begin
        if (!beat_toggle) begin
          rd_low      <= s_app_rd_data;
          beat_toggle <= 1'b1;
        end else begin
          rd_resp_valid <= 1'b1;
          rd_resp_data  <= {s_app_rd_data, rd_low};
          beat_toggle   <= 1'b0;
        end
      end

      // Issue and retire in the same cycle cancel out.
      case ({grant_rd, rd_done})
        2'b10:   rd_outstanding <= rd_outstanding + OUT_W'(1);
        2'b01:   rd_outstanding <= rd_outstanding - OUT_W'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_xem5010_mem_arbiter.sv
// Testbench for xem5010_mem_arbiter: directed scenario tasks followed by a
// randomized run checked against a rule-level reference model.
module tb_xem5010_mem_arbiter;

  localparam int AW      = 31;
  localparam int MAX_RUN = 8;
  localparam int MAX_OUT = 4;

  logic          s_clk = 1'b0;
  logic          s_rst = 1'b1;
  logic          s_phy_init_done = 1'b0;
  logic          wr_req_valid = 1'b0;
  logic [AW-1:0] wr_req_addr = '0;
  logic [63:0]   wr_req_data = '0;
  logic          wr_req_ready;
  logic          rd_req_valid = 1'b0;
  logic [AW-1:0] rd_req_addr = '0;
  logic          rd_req_ready;
  logic          rd_resp_valid;
  logic [63:0]   rd_resp_data;
  logic [3:0]    rd_outstanding;
  logic          s_app_af_afull = 1'b0;
  logic          s_app_wdf_afull = 1'b0;
  logic          s_app_rd_data_valid = 1'b0;
  logic [31:0]   s_app_rd_data = '0;
  logic          s_app_af_wren;
  logic [2:0]    s_app_af_cmd;
  logic [AW-1:0] s_app_af_addr;
  logic          s_app_wdf_wren;
  logic [31:0]   s_app_wdf_data;
  logic [3:0]    s_app_wdf_mask_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 s_clk = ~s_clk;

  xem5010_mem_arbiter #(
    .ADDR_WIDTH(AW), .MAX_RUN(MAX_RUN), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst), .s_phy_init_done(s_phy_init_done),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_outstanding(rd_outstanding),
    .s_app_af_afull(s_app_af_afull), .s_app_wdf_afull(s_app_wdf_afull),
    .s_app_rd_data_valid(s_app_rd_data_valid), .s_app_rd_data(s_app_rd_data),
    .s_app_af_wren(s_app_af_wren), .s_app_af_cmd(s_app_af_cmd), .s_app_af_addr(s_app_af_addr),
    .s_app_wdf_wren(s_app_wdf_wren), .s_app_wdf_data(s_app_wdf_data),
    .s_app_wdf_mask_data(s_app_wdf_mask_data)
  );

  task automatic idle_inputs();
    s_phy_init_done     = 1'b0;
    wr_req_valid        = 1'b0;
    rd_req_valid        = 1'b0;
    s_app_af_afull      = 1'b0;
    s_app_wdf_afull     = 1'b0;
    s_app_rd_data_valid = 1'b0;
  endtask

  // Leaves the bench on a falling edge with reset released.
  task automatic do_reset();
    @(negedge s_clk);
    s_rst = 1'b1;
    idle_inputs();
    @(negedge s_clk);
    s_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    s_phy_init_done = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = AW'(32'h0000_0abc); wr_req_data = 64'hdead_beef_cafe_f00d;
    @(negedge s_clk);
    wr_req_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = AW'(32'h0000_07ff);
    @(negedge s_clk);
    @(negedge s_clk);
    rd_req_valid = 1'b0;
    s_rst = 1'b1;
    @(negedge s_clk);
    n_tests++;
    if ({s_app_af_wren, s_app_af_cmd, s_app_af_addr} !== '0) begin
      n_fail++; $display("FAIL reset_af: got wren=%0b cmd=%0b addr=%h, want all 0", s_app_af_wren, s_app_af_cmd, s_app_af_addr);
    end
    n_tests++;
    if ({s_app_wdf_wren, s_app_wdf_data, s_app_wdf_mask_data} !== '0) begin
      n_fail++; $display("FAIL reset_wdf: got wren=%0b data=%h mask=%h, want all 0", s_app_wdf_wren, s_app_wdf_data, s_app_wdf_mask_data);
    end
    n_tests++;
    if ({rd_resp_valid, rd_resp_data, rd_outstanding} !== '0) begin
      n_fail++; $display("FAIL reset_rd: got valid=%0b data=%h outstanding=%0d, want all 0", rd_resp_valid, rd_resp_data, rd_outstanding);
    end
    s_rst = 1'b0;
  endtask

  task automatic test_phy_gate();
    do_reset();
    wr_req_valid = 1'b1; wr_req_addr = AW'(32'h20); wr_req_data = 64'h1;
    rd_req_valid = 1'b1; rd_req_addr = AW'(32'h40);
    repeat (20) begin
      #1;
      n_tests++;
      if (wr_req_ready !== 1'b0 || rd_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL phy_gate_ready: got wr=%b rd=%b, want 0 0", wr_req_ready, rd_req_ready);
      end
      @(negedge s_clk);
      n_tests++;
      if (s_app_af_wren !== 1'b0) begin
        n_fail++; $display("FAIL phy_gate_af_wren: got %b, want 0", s_app_af_wren);
      end
    end
    s_phy_init_done = 1'b1;
    #1;
    n_tests++;
    if (wr_req_ready !== 1'b1 || rd_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL phy_first_grant: got wr=%b rd=%b, want 1 0", wr_req_ready, rd_req_ready);
    end
    @(negedge s_clk);
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    s_phy_init_done = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = AW'(32'h10); wr_req_data = 64'h1122_3344_5566_7788;
    #1;
    n_tests++;
    if (wr_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_ready: got %b, want 1", wr_req_ready);
    end
    @(negedge s_clk);
    wr_req_valid = 1'b0;
    n_tests++;
    if (s_app_af_wren !== 1'b1 || s_app_af_cmd !== 3'b000 || s_app_af_addr !== AW'(32'h10)
        || s_app_wdf_wren !== 1'b1 || s_app_wdf_data !== 32'h5566_7788) begin
      n_fail++; $display("FAIL wr_t1: got af=%b cmd=%b addr=%h wdf=%b %h, want 1 000 10 1 55667788",
                         s_app_af_wren, s_app_af_cmd, s_app_af_addr, s_app_wdf_wren, s_app_wdf_data);
    end
    @(negedge s_clk);
    n_tests++;
    if (s_app_af_wren !== 1'b0 || s_app_wdf_wren !== 1'b1 || s_app_wdf_data !== 32'h1122_3344) begin
      n_fail++; $display("FAIL wr_t2: got af=%b wdf=%b %h, want 0 1 11223344", s_app_af_wren, s_app_wdf_wren, s_app_wdf_data);
    end
    @(negedge s_clk);
    n_tests++;
    if (s_app_wdf_wren !== 1'b0) begin
      n_fail++; $display("FAIL wr_t3: wdf_wren got %b, want 0", s_app_wdf_wren);
    end
  endtask

  // Both requesters always valid, no read returns: 8 writes, then reads until
  // the outstanding limit blocks them, then writes again.
  task automatic test_fairness();
    logic grants[$];
    logic expected;
    int   cyc;
    do_reset();
    s_phy_init_done = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = AW'(32'h100); wr_req_data = 64'h0123_4567_89ab_cdef;
    rd_req_valid = 1'b1; rd_req_addr = AW'(32'h200);
    cyc = 0;
    while (grants.size() < MAX_RUN + MAX_OUT + 1 && cyc < 60) begin
      #1;
      if (wr_req_ready && rd_req_ready) begin
        n_tests++; n_fail++;
        $display("FAIL fair_dual_grant: both ready in cycle %0d", cyc);
      end else if (wr_req_ready) grants.push_back(1'b0);
      else if (rd_req_ready) grants.push_back(1'b1);
      @(negedge s_clk);
      cyc++;
    end
    n_tests++;
    if (grants.size() != MAX_RUN + MAX_OUT + 1) begin
      n_fail++; $display("FAIL fair_timeout: got %0d grants, want %0d", grants.size(), MAX_RUN + MAX_OUT + 1);
    end
    for (int i = 0; i < grants.size(); i++) begin
      expected = (i >= MAX_RUN && i < MAX_RUN + MAX_OUT);
      n_tests++;
      if (grants[i] !== expected) begin
        n_fail++; $display("FAIL fair_grant_%0d: got %s, want %s", i, grants[i] ? "read" : "write", expected ? "read" : "write");
      end
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    @(negedge s_clk);
  endtask

  task automatic test_outstanding();
    int n_rd_cmd;
    do_reset();
    // Three stray beats with nothing outstanding must vanish without a pulse.
    s_app_rd_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_app_rd_data = 32'h5a5a_0000 + 32'(i);
      @(negedge s_clk);
      n_tests++;
      if (rd_resp_valid !== 1'b0 || rd_outstanding !== 4'd0) begin
        n_fail++; $display("FAIL stray_beat_%0d: got valid=%b outstanding=%0d, want 0 0", i, rd_resp_valid, rd_outstanding);
      end
    end
    s_app_rd_data_valid = 1'b0;
    s_phy_init_done = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = AW'(32'h300);
    n_rd_cmd = 0;
    repeat (10) begin
      @(negedge s_clk);
      if (s_app_af_wren && s_app_af_cmd == 3'b001) n_rd_cmd++;
    end
    n_tests++;
    if (n_rd_cmd != MAX_OUT) begin
      n_fail++; $display("FAIL rd_cmd_count: got %0d, want %0d", n_rd_cmd, MAX_OUT);
    end
    n_tests++;
    if (rd_outstanding !== 4'(MAX_OUT) || rd_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rd_limit: got outstanding=%0d ready=%b, want %0d 0", rd_outstanding, rd_req_ready, MAX_OUT);
    end
    rd_req_valid = 1'b0;
    s_app_rd_data_valid = 1'b1; s_app_rd_data = 32'haaaa_0000;
    @(negedge s_clk);
    s_app_rd_data = 32'hbbbb_1111;
    @(negedge s_clk);
    s_app_rd_data_valid = 1'b0;
    n_tests++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== 64'hbbbb_1111_aaaa_0000 || rd_outstanding !== 4'd3) begin
      n_fail++; $display("FAIL rd_resp: got valid=%b data=%h outstanding=%0d, want 1 bbbb1111aaaa0000 3",
                         rd_resp_valid, rd_resp_data, rd_outstanding);
    end
    @(negedge s_clk);
    n_tests++;
    if (rd_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_resp_pulse: valid got %b, want 0", rd_resp_valid);
    end
  endtask

  task automatic test_afull();
    do_reset();
    s_phy_init_done = 1'b1; s_app_af_afull = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = AW'(32'h400); wr_req_data = 64'h7777_6666_5555_4444;
    rd_req_valid = 1'b1; rd_req_addr = AW'(32'h500);
    repeat (5) begin
      #1;
      n_tests++;
      if (wr_req_ready !== 1'b0 || rd_req_ready !== 1'b0) begin
        n_fail++; $display("FAIL af_afull_ready: got wr=%b rd=%b, want 0 0", wr_req_ready, rd_req_ready);
      end
      @(negedge s_clk);
      n_tests++;
      if (s_app_af_wren !== 1'b0) begin
        n_fail++; $display("FAIL af_afull_wren: got %b, want 0", s_app_af_wren);
      end
    end
    // Write-data almost full blocks writes only; the read goes instead.
    s_app_af_afull = 1'b0; s_app_wdf_afull = 1'b1;
    #1;
    n_tests++;
    if (wr_req_ready !== 1'b0 || rd_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wdf_afull_arb: got wr=%b rd=%b, want 0 1", wr_req_ready, rd_req_ready);
    end
    @(negedge s_clk);
    rd_req_valid = 1'b0; s_app_wdf_afull = 1'b0;
    #1;
    n_tests++;
    if (wr_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wdf_clear_wr: ready got %b, want 1", wr_req_ready);
    end
    @(negedge s_clk);
    wr_req_valid = 1'b0; s_app_wdf_afull = 1'b1;
    n_tests++;
    if (s_app_af_wren !== 1'b1 || s_app_wdf_data !== 32'h5555_4444) begin
      n_fail++; $display("FAIL wdf_afull_lo: got af=%b wdf=%h, want 1 55554444", s_app_af_wren, s_app_wdf_data);
    end
    @(negedge s_clk);
    n_tests++;
    if (s_app_wdf_wren !== 1'b1 || s_app_wdf_data !== 32'h7777_6666) begin
      n_fail++; $display("FAIL wdf_afull_hi: got wren=%b wdf=%h, want 1 77776666", s_app_wdf_wren, s_app_wdf_data);
    end
    s_app_wdf_afull = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    s_phy_init_done = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = AW'(32'h600);
    @(negedge s_clk);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b1; wr_req_addr = AW'(32'h700); wr_req_data = 64'h9999_8888_7777_6666;
    @(negedge s_clk);
    wr_req_valid = 1'b0;
    s_rst = 1'b1;
    @(negedge s_clk);
    n_tests++;
    if ({s_app_af_wren, s_app_af_cmd, s_app_af_addr, s_app_wdf_wren, s_app_wdf_data} !== '0
        || rd_outstanding !== 4'd0) begin
      n_fail++; $display("FAIL midwr_reset: got af=%b cmd=%b addr=%h wdf=%b %h outstanding=%0d, want all 0",
                         s_app_af_wren, s_app_af_cmd, s_app_af_addr, s_app_wdf_wren, s_app_wdf_data, rd_outstanding);
    end
    s_rst = 1'b0;
    wr_req_valid = 1'b1;
    #1;
    n_tests++;
    if (wr_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midwr_idle: wr_ready got %b, want 1", wr_req_ready);
    end
    @(negedge s_clk);
    wr_req_valid = 1'b0;
    n_tests++;
    if (s_app_af_wren !== 1'b1 || s_app_wdf_data !== 32'h7777_6666) begin
      n_fail++; $display("FAIL midwr_regrant: got af=%b wdf=%h, want 1 77776666", s_app_af_wren, s_app_wdf_data);
    end
    @(negedge s_clk);
  endtask

  // Randomized traffic against a reference model of the arbitration rules.
  task automatic test_random(input int cycles);
    logic          m_hi_pend, m_half, m_last, t;
    logic [31:0]   m_hi_word, m_low;
    int            m_run, m_out, retire;
    logic          e_af, e_wdf, e_rv;
    logic [2:0]    e_cmd;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;
    logic [63:0]   e_rdata;
    logic          wr_ok, rd_ok, pick_wr, pick_rd, wr_taken, rd_taken;
    do_reset();
    m_hi_pend = 0; m_half = 0; m_last = 0; m_hi_word = '0; m_low = '0; m_run = 0; m_out = 0;
    e_af = 0; e_wdf = 0; e_rv = 0; e_cmd = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    wr_taken = 0; rd_taken = 0;
    for (int c = 0; c < cycles; c++) begin
      n_tests++;
      if (s_app_af_wren !== e_af || s_app_af_cmd !== e_cmd || s_app_af_addr !== e_addr) begin
        n_fail++; $display("FAIL rnd_af c=%0d: got %b %b %h, want %b %b %h", c, s_app_af_wren, s_app_af_cmd, s_app_af_addr, e_af, e_cmd, e_addr);
      end
      n_tests++;
      if (s_app_wdf_wren !== e_wdf || s_app_wdf_data !== e_wdata) begin
        n_fail++; $display("FAIL rnd_wdf c=%0d: got %b %h, want %b %h", c, s_app_wdf_wren, s_app_wdf_data, e_wdf, e_wdata);
      end
      n_tests++;
      if (rd_resp_valid !== e_rv || rd_resp_data !== e_rdata || rd_outstanding !== 4'(m_out)) begin
        n_fail++; $display("FAIL rnd_rd c=%0d: got %b %h %0d, want %b %h %0d", c, rd_resp_valid, rd_resp_data, rd_outstanding, e_rv, e_rdata, m_out);
      end
      s_phy_init_done = ($urandom_range(0, 19) != 0);
      if (!wr_req_valid || wr_taken) begin
        wr_req_valid = ($urandom_range(0, 2) != 0);
        wr_req_addr  = AW'($urandom);
        wr_req_data  = {$urandom, $urandom};
      end
      if (!rd_req_valid || rd_taken) begin
        rd_req_valid = ($urandom_range(0, 2) != 0);
        rd_req_addr  = AW'($urandom);
      end
      s_app_af_afull      = ($urandom_range(0, 9) == 0);
      s_app_wdf_afull     = ($urandom_range(0, 9) == 0);
      s_app_rd_data_valid = ($urandom_range(0, 2) == 0);
      s_app_rd_data       = $urandom;
      #1;
      wr_ok = !m_hi_pend && s_phy_init_done && wr_req_valid && !s_app_af_afull && !s_app_wdf_afull;
      rd_ok = !m_hi_pend && s_phy_init_done && rd_req_valid && !s_app_af_afull && (m_out < MAX_OUT);
      if (wr_ok && rd_ok) pick_wr = (m_run < MAX_RUN) ? (m_last == 1'b0) : (m_last == 1'b1);
      else pick_wr = wr_ok;
      pick_rd = rd_ok && !pick_wr;
      n_tests++;
      if (wr_req_ready !== pick_wr || rd_req_ready !== pick_rd) begin
        n_fail++; $display("FAIL rnd_ready c=%0d: got wr=%b rd=%b, want %b %b", c, wr_req_ready, rd_req_ready, pick_wr, pick_rd);
      end
      e_rv = 0;
      if (pick_wr) begin
        e_af = 1; e_cmd = 3'b000; e_addr = wr_req_addr; e_wdf = 1; e_wdata = wr_req_data[31:0];
        m_hi_pend = 1; m_hi_word = wr_req_data[63:32];
      end else if (m_hi_pend) begin
        e_af = 0; e_wdf = 1; e_wdata = m_hi_word; m_hi_pend = 0;
      end else if (pick_rd) begin
        e_af = 1; e_cmd = 3'b001; e_addr = rd_req_addr; e_wdf = 0;
      end else begin
        e_af = 0; e_wdf = 0;
      end
      if (pick_wr || pick_rd) begin
        t = pick_rd;
        if (t == m_last) m_run = (m_run < 255) ? m_run + 1 : 255;
        else begin m_last = t; m_run = 1; end
      end
      retire = 0;
      if (s_app_rd_data_valid && m_out > 0) begin
        if (!m_half) begin m_low = s_app_rd_data; m_half = 1; end
        else begin e_rv = 1; e_rdata = {s_app_rd_data, m_low}; m_half = 0; retire = 1; end
      end
      m_out = m_out + (pick_rd ? 1 : 0) - retire;
      wr_taken = pick_wr; rd_taken = pick_rd;
      @(negedge s_clk);
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_phy_gate();
    test_single_write();
    test_fairness();
    test_outstanding();
    test_afull();
    test_reset_mid_write();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
